div_share_ctrl: RTL

- Sequences one shared iterative 32-bit divider between two execute lanes; LoongArch DIV.W, DIVU.W, MOD.W, MODU.W.
- Sits beside the combinational ALU in stage 3. Lanes issue divide ops here instead of to the ALU.
- Results return with the requester's tag for writeback.
- Round-robin arbitration, valid/ready handshakes on both sides, and flush on pipeline redirect.

---
 rtl/core_types.sv | 32 +++
 rtl/div_rr_arbiter.sv | 17 +
 rtl/div_share_ctrl.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/core_types.sv
// Shared types for the shared divider controller: op and state encodings, iteration count.
// Provides div_lzc only when DIV_EARLY_OUT_EN is defined.
package core_types;

  localparam int DIV_ITER = 32;

  typedef enum logic [1:0] {
    DIV_W  = 2'd0,
    DIVU_W = 2'd1,
    MOD_W  = 2'd2,
    MODU_W = 2'd3
  } div_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

`ifdef DIV_EARLY_OUT_EN
  // A zero input reports 31 so that a zero dividend still takes one CALC step.
  function automatic logic [4:0] div_lzc(input logic [31:0] v);
    logic [4:0] n;
    n = 5'd31;
    for (int i = 0; i < 32; i++) begin
      if (v[i]) n = 5'(31 - i);
    end
    return n;
  endfunction
`endif

endpackage

// File: rtl/div_rr_arbiter.sv
// Two-lane round-robin grant for the shared divider; purely combinational.
module div_rr_arbiter (
  input  logic [1:0] valid_i,
  input  logic       rr_ptr_i,
  input  logic       enable_i,
  output logic [1:0] grant_o
);

  always_comb begin
    grant_o = 2'b00;
    if (enable_i) begin
      if (valid_i == 2'b11) grant_o = rr_ptr_i ? 2'b10 : 2'b01;
      else                  grant_o = valid_i;
    end
  end

endmodule

// File: rtl/div_share_ctrl.sv
// One iterative restoring divider shared by two execute lanes (DIV.W/DIVU.W/MOD.W/MODU.W).
// Define DIV_EARLY_OUT_EN to skip the dividend's leading-zero iterations.
module div_share_ctrl
  import core_types::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 6
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [1:0]                 req_valid_i,
  output logic [1:0]                 req_ready_o,
  input  logic [1:0][1:0]            req_op_i,
  input  logic [1:0][DATA_WIDTH-1:0] req_src1_i,
  input  logic [1:0][DATA_WIDTH-1:0] req_src2_i,
  input  logic [1:0][TAG_WIDTH-1:0]  req_tag_i,
  input  logic                       flush_i,
  output logic                       resp_valid_o,
  input  logic                       resp_ready_i,
  output logic                       resp_lane_o,
  output logic [TAG_WIDTH-1:0]       resp_tag_o,
  output logic [DATA_WIDTH-1:0]      resp_data_o,
  output logic                       busy_o
);

  div_state_t            state_q, state_d;
  logic                  rr_ptr_q, rr_ptr_d;
  logic [4:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] rem_q, rem_d;
  logic [DATA_WIDTH-1:0] quo_q, quo_d;
  logic [DATA_WIDTH-1:0] dvs_q, dvs_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  lane_q, lane_d;
  logic [TAG_WIDTH-1:0]  tag_q, tag_d;
  logic                  is_mod_q, is_mod_d;
  logic                  qneg_q, qneg_d;
  logic                  rneg_q, rneg_d;

  logic [1:0]            grant;
  logic                  sel;
  div_op_t               sel_op;
  logic                  sel_signed;
  logic                  sel_is_mod;
  logic [DATA_WIDTH-1:0] sel_a, sel_b, abs_a, abs_b;
  logic [DATA_WIDTH:0]   shifted;
  logic                  ge;
  logic [DATA_WIDTH-1:0] step_rem, step_quo, fix_q, fix_r;

  // Reset is folded into the enable so no lane sees ready while rst is low.
  div_rr_arbiter u_arb (
    .valid_i  (req_valid_i),
    .rr_ptr_i (rr_ptr_q),
    .enable_i ((state_q == IDLE) && !flush_i && rst),
    .grant_o  (grant)
  );

  assign sel        = grant[1];
  assign sel_op     = div_op_t'(req_op_i[sel]);
  assign sel_a      = req_src1_i[sel];
  assign sel_b      = req_src2_i[sel];
  assign sel_signed = (sel_op == DIV_W) || (sel_op == MOD_W);
  assign sel_is_mod = (sel_op == MOD_W) || (sel_op == MODU_W);
  assign abs_a      = (sel_signed && sel_a[DATA_WIDTH-1]) ? -sel_a : sel_a;
  assign abs_b      = (sel_signed && sel_b[DATA_WIDTH-1]) ? -sel_b : sel_b;

`ifdef DIV_EARLY_OUT_EN
  logic [4:0] lzc;
  assign lzc = div_lzc(abs_a);
`endif

  // One restoring step: the 33-bit trial value never exceeds twice the divisor.
  assign shifted  = {rem_q, quo_q[DATA_WIDTH-1]};
  assign ge       = shifted >= {1'b0, dvs_q};
  assign step_rem = ge ? DATA_WIDTH'(shifted - {1'b0, dvs_q}) : shifted[DATA_WIDTH-1:0];
  assign step_quo = {quo_q[DATA_WIDTH-2:0], ge};
  assign fix_q    = qneg_q ? -step_quo : step_quo;
  assign fix_r    = rneg_q ? -step_rem : step_rem;

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    data_d   = data_q;
    lane_d   = lane_q;
    tag_d    = tag_q;
    is_mod_d = is_mod_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    case (state_q)
      IDLE: begin
        if (|grant) begin
          lane_d   = sel;
          tag_d    = req_tag_i[sel];
          is_mod_d = sel_is_mod;
          qneg_d   = sel_signed && (sel_a[DATA_WIDTH-1] ^ sel_b[DATA_WIDTH-1]);
          rneg_d   = sel_signed && sel_a[DATA_WIDTH-1];
          rr_ptr_d = ~sel;
          if (sel_b == '0) begin
            state_d = DONE;
            data_d  = sel_is_mod ? sel_a : '1;
          end else begin
            state_d = CALC;
            rem_d   = '0;
            dvs_d   = abs_b;
`ifdef DIV_EARLY_OUT_EN
            quo_d   = abs_a << lzc;
            cnt_d   = 5'(DIV_ITER - 1) - lzc;
`else
            quo_d   = abs_a;
            cnt_d   = 5'(DIV_ITER - 1);
`endif
          end
        end
      end
      CALC: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd0) begin
          state_d = DONE;
          cnt_d   = 5'd0;
          data_d  = is_mod_q ? fix_r : fix_q;
        end
      end
      DONE: begin
        if (resp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Flush outranks everything, including a result being accepted this cycle.
    if (flush_i) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= 1'b0;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      data_q   <= '0;
      lane_q   <= 1'b0;
      tag_q    <= '0;
      is_mod_q <= 1'b0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      data_q   <= data_d;
      lane_q   <= lane_d;
      tag_q    <= tag_d;
      is_mod_q <= is_mod_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
    end
  end

  assign req_ready_o  = grant;
  assign resp_valid_o = (state_q == DONE);
  assign resp_lane_o  = lane_q;
  assign resp_tag_o   = tag_q;
  assign resp_data_o  = data_q;
  assign busy_o       = (state_q != IDLE);

endmodule
